// File: rtl/rca_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : rca_result_collector_if
// Brief    : Issue credit, adder result and FIFO output signals of the collector.
// Revision : 1.0
// ============================================================================
interface rca_result_collector_if #(
  parameter int DEPTH = 4,
  parameter int W     = 5
);
  logic                   issue_valid;
  logic                   issue_ready;
  logic [3:0]             res_sum;
  logic                   res_cout;
  logic                   out_valid;
  logic                   out_ready;
  logic [W-1:0]           out_data;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow_err;

  modport master (
    output issue_valid, res_sum, res_cout, out_ready,
    input  issue_ready, out_valid, out_data, count, overflow_err
  );

  modport slave (
    input  issue_valid, res_sum, res_cout, out_ready,
    output issue_ready, out_valid, out_data, count, overflow_err
  );
endinterface
`default_nettype wire

// File: rtl/rca_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : rca_result_collector
// Brief    : Tracks adder issue slots, captures results into a show-ahead FIFO.
// Revision : 1.0
// ============================================================================
module rca_result_collector #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4,
  parameter int W       = 5
) (
  input wire                    clk,
  input wire                    rst,
  rca_result_collector_if.slave bus
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_crd_w = $clog2(LATENCY + DEPTH + 1);
  localparam logic [c_crd_w-1:0] c_depth_crd = c_crd_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

  logic [LATENCY-1:0] r_vld;
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic [W-1:0]       r_mem [DEPTH];
  logic [W-1:0]       r_last;
  logic               r_overflow;

  logic               w_fire;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_wr_en;
  logic               w_ready;
  logic [c_crd_w-1:0] w_in_flight;
  logic [c_crd_w-1:0] w_credits_used;
  logic [W-1:0]       w_wdata;

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_in_flight = w_in_flight + c_crd_w'(r_vld[i]);
    end
  end

  // Every issued op reserves a FIFO slot until it is popped, so the
  // unstallable adder can never deliver into a full FIFO.
  assign w_credits_used = w_in_flight + c_crd_w'(r_count);
  assign w_ready        = (w_credits_used < c_depth_crd);
  assign w_fire         = bus.issue_valid & w_ready;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth_cnt);
  assign w_push  = r_vld[LATENCY-1];
  assign w_pop   = ~w_empty & bus.out_ready;
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_wdata = W'({bus.res_cout, bus.res_sum});

  generate
    if (LATENCY == 1) begin : g_vld_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= '0;
        end else begin
          r_vld <= w_fire;
        end
      end
    end else begin : g_vld_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= '0;
        end else begin
          r_vld <= {r_vld[LATENCY-2:0], w_fire};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_last     <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_mem[r_wptr] <= w_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      // The popped head is remembered so an empty FIFO keeps showing it.
      if (w_pop) begin
        r_last <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wr_en && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr_en && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.issue_ready  = w_ready;
  assign bus.out_valid    = ~w_empty;
  assign bus.out_data     = w_empty ? r_last : r_mem[r_rptr];
  assign bus.count        = r_count;
  assign bus.overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rca_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_result_collector
// Brief    : Directed bench with a 4-stage adder model feeding the collector.
// Revision : 1.0
// ============================================================================
module tb_rca_result_collector;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 4;
  localparam int W       = 5;

  logic clk;
  logic rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       ovr_en;
  logic [4:0] ovr_val;
  logic [4:0] pipe [LATENCY];

  int n_tests;
  int n_fail;

  rca_result_collector_if #(.DEPTH(DEPTH), .W(W)) bus ();

  rca_result_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running adder: operands sampled at an edge appear LATENCY edges later.
  always @(posedge clk) begin
    pipe[0] <= {1'b0, a} + {1'b0, b} + {4'b0, cin};
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.res_sum  = ovr_en ? ovr_val[3:0] : pipe[LATENCY-1][3:0];
  assign bus.res_cout = ovr_en ? ovr_val[4]   : pipe[LATENCY-1][4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 5'd0) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", bus.out_data); end
    n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    n_tests++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", bus.overflow_err); end
    n_tests++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %0b expected 1", bus.issue_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit early;
    bus.out_ready = 1'b1;
    a = 4'd3; b = 4'd5; cin = 1'b0;
    bus.issue_valid = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
    early = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (bus.out_valid) early = 1'b1;
      tick();
    end
    n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %0b expected 0", early); end
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_c5: got %0b expected 1", bus.out_valid); end
    n_tests++; if (bus.out_data !== 5'b01000) begin n_fail++; $display("FAIL single_data_c5: got %0h expected 08", bus.out_data); end
    n_tests++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL single_count_c5: got %0d expected 1", bus.count); end
    tick();
    n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL single_count_c6: got %0d expected 0", bus.count); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_c6: got %0b expected 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 5'b01000) begin n_fail++; $display("FAIL single_hold_data: got %0h expected 08", bus.out_data); end
  endtask

  task automatic test_back_to_back();
    int exp_idx [16];
    bit exp_rdy [10];
    int nissued;
    exp_idx = '{-1, -1, -1, -1, -1, 0, 1, 2, 3, -1, -1, 4, 5, 6, 7, -1};
    exp_rdy = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    nissued = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.issue_valid = (nissued < 8);
      a = 4'(nissued); b = 4'd15; cin = 1'b1;
      if (k < 10) begin
        n_tests++;
        if (bus.issue_ready !== exp_rdy[k]) begin n_fail++; $display("FAIL b2b_ready c%0d: got %0b expected %0b", k, bus.issue_ready, exp_rdy[k]); end
      end
      n_tests++;
      if (exp_idx[k] < 0) begin
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle c%0d: got valid %0b expected 0", k, bus.out_valid); end
      end else if (bus.out_valid !== 1'b1 || bus.out_data !== {1'b1, 4'(exp_idx[k])}) begin
        n_fail++; $display("FAIL b2b_result c%0d: got valid %0b data %0h expected valid 1 data %0h", k, bus.out_valid, bus.out_data, {1'b1, 4'(exp_idx[k])});
      end
      if (bus.issue_valid && bus.issue_ready) nissued++;
      tick();
    end
    bus.issue_valid = 1'b0;
    n_tests++; if (nissued != 8) begin n_fail++; $display("FAIL b2b_issued: got %0d expected 8", nissued); end
  endtask

  task automatic test_fill_drain();
    int fires;
    fires = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.issue_valid = 1'b1;
      a = 4'(fires + 1); b = 4'd2; cin = 1'b0;
      if (bus.issue_ready) fires++;
      tick();
    end
    n_tests++; if (fires != 4) begin n_fail++; $display("FAIL fill_fires: got %0d expected 4", fires); end
    n_tests++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", bus.count); end
    n_tests++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %0b expected 0", bus.issue_ready); end
    n_tests++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL fill_overflow: got %0b expected 0", bus.overflow_err); end
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 5'd3) begin n_fail++; $display("FAIL fill_head: got valid %0b data %0h expected valid 1 data 03", bus.out_valid, bus.out_data); end
    bus.issue_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_tests++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_rise: got %0b expected 1", bus.issue_ready); end
    n_tests++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL drain_count: got %0d expected 3", bus.count); end
    for (int j = 1; j < 4; j++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 5'(j + 3)) begin n_fail++; $display("FAIL drain_order %0d: got valid %0b data %0h expected valid 1 data %0h", j, bus.out_valid, bus.out_data, 5'(j + 3)); end
      tick();
    end
    n_tests++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got count %0d valid %0b expected 0 0", bus.count, bus.out_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [4:0] exp_q [4];
    exp_q = '{5'd3, 5'd5, 5'd7, 5'h1A};
    bus.out_ready = 1'b0;
    for (int k = 0, n = 0; k < 10; k++) begin
      bus.issue_valid = 1'b1;
      a = 4'(n); b = 4'(n); cin = 1'b1;
      if (bus.issue_ready) n++;
      tick();
    end
    bus.issue_valid = 1'b0;
    n_tests++; if (bus.count !== 3'd4 || bus.out_data !== 5'd1) begin n_fail++; $display("FAIL fpp_full: got count %0d data %0h expected 4 01", bus.count, bus.out_data); end
    ovr_en = 1'b1; ovr_val = 5'h1A;
    force dut.r_vld = 4'b1000;
    bus.out_ready = 1'b1;
    tick();
    force dut.r_vld = 4'b0000;
    #1 release dut.r_vld;
    ovr_en = 1'b0;
    n_tests++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fpp_count: got %0d expected 4", bus.count); end
    n_tests++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow: got %0b expected 0", bus.overflow_err); end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[j]) begin n_fail++; $display("FAIL fpp_order %0d: got valid %0b data %0h expected valid 1 data %0h", j, bus.out_valid, bus.out_data, exp_q[j]); end
      @(posedge clk); #1;
    end
    n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL fpp_empty: got %0d expected 0", bus.count); end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    for (int k = 0, n = 0; k < 10; k++) begin
      bus.issue_valid = 1'b1;
      a = 4'(n + 8); b = 4'd0; cin = 1'b0;
      if (bus.issue_ready) n++;
      tick();
    end
    bus.issue_valid = 1'b0;
    ovr_en = 1'b1; ovr_val = 5'h1F;
    force dut.r_vld = 4'b1000;
    tick();
    force dut.r_vld = 4'b0000;
    #1 release dut.r_vld;
    ovr_en = 1'b0;
    n_tests++; if (bus.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b expected 1", bus.overflow_err); end
    n_tests++; if (bus.count !== 3'd4 || bus.out_data !== 5'd8) begin n_fail++; $display("FAIL ovf_state: got count %0d data %0h expected 4 08", bus.count, bus.out_data); end
    repeat (3) tick();
    n_tests++; if (bus.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", bus.overflow_err); end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 5'(j + 8)) begin n_fail++; $display("FAIL ovf_order %0d: got valid %0b data %0h expected valid 1 data %0h", j, bus.out_valid, bus.out_data, 5'(j + 8)); end
      tick();
    end
    n_tests++; if (bus.out_valid !== 1'b0 || bus.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_after_drain: got valid %0b ovf %0b expected 0 1", bus.out_valid, bus.overflow_err); end
  endtask

  task automatic test_async_reset();
    bit stale;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.issue_valid = 1'b1;
      a = 4'(k); b = 4'd1; cin = 1'b0;
      tick();
    end
    bus.issue_valid = 1'b0;
    tick();
    tick();
    n_tests++; if (bus.count !== 3'd2 || bus.out_data !== 5'd1) begin n_fail++; $display("FAIL arst_pre: got count %0d data %0h expected 2 01", bus.count, bus.out_data); end
    #3 rst = 1'b1;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin n_fail++; $display("FAIL arst_immediate: got valid %0b count %0d expected 0 0", bus.out_valid, bus.count); end
    n_tests++; if (bus.out_data !== 5'd0) begin n_fail++; $display("FAIL arst_data: got %0h expected 0", bus.out_data); end
    n_tests++; if (bus.overflow_err !== 1'b0 || bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL arst_flags: got ovf %0b ready %0b expected 0 1", bus.overflow_err, bus.issue_ready); end
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) stale = 1'b1;
      tick();
    end
    n_tests++; if (stale !== 1'b0) begin n_fail++; $display("FAIL arst_stale: got %0b expected 0", stale); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.issue_valid = 1'b0;
    bus.out_ready = 1'b0;
    a = 4'd0; b = 4'd0; cin = 1'b0;
    ovr_en = 1'b0; ovr_val = 5'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_drain();
    test_full_push_pop();
    test_overflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
